serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing diff = a − b, least-significant bit first, one bit per clock. It is built around the team's 1-bit full-subtractor cell fS, with a registered borrow fed back between cycles. A start/busy/done handshake lets it sit downstream of an operand source and upstream of any result consumer. It trades latency for area against a WIDTH-wide ripple chain of fS cells.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to load operands; accepted only in IDLE
a  input  WIDTH  minuend, sampled on the accepting edge
b  input  WIDTH  subtrahend, sampled on the accepting edge
busy  output  1  high while bits are being processed (state RUN)
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  (a − b) mod 2^WIDTH; valid while busy=0 after the first done
borrow_out  output  1  final borrow, equal to (a < b) unsigned; valid under the same condition as diff

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; a_sh, b_sh, diff, borrow register, count all 0. Outputs busy=0, done=0, diff=0, borrow_out=0.
- Reset asserted mid-operation aborts immediately. No done is produced and the partial result is discarded (cleared to 0).
- States: IDLE, RUN, DONE. Encoding is 2-bit binary; outputs are decoded from state, Moore style.
- IDLE:
  - start=1 at an edge loads a_sh<=a, b_sh<=b, borrow<=0, count<=0, and moves to RUN.
  - start=0 stays in IDLE; diff and borrow_out hold their last values.
- RUN: each edge feeds the fS cell with f_A=a_sh[0], f_B=b_sh[0], f_Bi=borrow, then:
  - a_sh and b_sh shift right by one.
  - diff shifts right, with f_Df entering at bit WIDTH-1.
  - borrow<=f_Bo; count<=count+1.
  - When count==WIDTH-1 at the edge, move to DONE.
- DONE: done=1 for exactly one cycle; the next edge moves to IDLE unconditionally.
- Latency: start accepted at edge E. busy=1 for edges E+1..E+WIDTH (exactly WIDTH cycles). done=1 in the cycle following edge E+WIDTH. A new start is accepted no earlier than edge E+WIDTH+2.
- start while in RUN or DONE is ignored. It is not queued, and a/b changes have no effect.
- diff and borrow_out change during RUN and are meaningful only while busy=0. They hold from DONE until the next accepted start.
- borrow_out is driven directly by the borrow register.
- count width is $clog2(WIDTH); count wraps only via reload in IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. A signed interpretation of diff is the caller's responsibility.

Decomposition:
- Shared package: state typedef/localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
- Sub-module: one instance of the existing fS cell (f_A, f_B, f_Bi, f_Df, f_Bo). It is the only combinational datapath.
- Shift registers, counter and FSM stay in serial_subtractor.

Test Plan:
1. Reset, then start with a=8'd100, b=8'd37: busy high 8 cycles, done in the 9th cycle after the start edge, diff=8'h3F, borrow_out=0.
2. a=8'd5, b=8'd10: diff=8'hFB, borrow_out=1. Then a=8'h00, b=8'hFF: diff=8'h01, borrow_out=1. Then a=b=8'hA5: diff=8'h00, borrow_out=0.
3. Pulse start again 3 cycles into RUN with different operands: ignored; the result matches the first operands, and exactly one done pulse occurs.
4. Drop rst_n 4 cycles into RUN: busy, done, diff and borrow_out go to 0 asynchronously; no done after release; the next start computes normally.
5. Hold start=1 continuously with a=8'd200, b=8'd1: back-to-back operations every WIDTH+2 cycles, each giving diff=8'd199, borrow_out=0.
6. Random a/b with WIDTH=8 and WIDTH=16 (≥1000 vectors each): diff and borrow_out match a reference model of {borrow, diff} = {1'b0, a} − {1'b0, b}.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared FSM state encoding for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// 1-bit full-subtractor cell: f_Df = f_A - f_B - f_Bi, with borrow out.
module serial_subtractor_fs (
    input  logic f_A,
    input  logic f_B,
    input  logic f_Bi,
    output logic f_Df,
    output logic f_Bo
);

    assign f_Df = f_A ^ f_B ^ f_Bi;
    assign f_Bo = (~f_A & (f_B | f_Bi)) | (f_B & f_Bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock,
// with a start/busy/done handshake around a single full-subtractor cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic             done_r;
    logic             fs_df_s;
    logic             fs_bo_s;

    serial_subtractor_fs u_fs (
        .f_A  (a_sh_r[0]),
        .f_B  (b_sh_r[0]),
        .f_Bi (borrow_r),
        .f_Df (fs_df_s),
        .f_Bo (fs_bo_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; start is only honoured from IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_r == LAST_BIT) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Moore status flags, registered from the next state so they track state_r exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_RUN);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    // Operand load, serial shift datapath, borrow feedback and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            count_r  <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        borrow_r <= 1'b0;
                        count_r  <= {CW{1'b0}};
                    end
                end
                ST_RUN: begin
                    // result bits enter at the MSB so after WIDTH shifts bit 0 sits at diff[0]
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    diff_r   <= {fs_df_s, diff_r[WIDTH-1:1]};
                    borrow_r <= fs_bo_s;
                    count_r  <= count_r + CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=16 instances
// checked every cycle against a latency/arithmetic model plus literal expectations.
module tb_serial_subtractor;

    typedef struct {
        int          phase;
        logic [31:0] pend;
        logic        pbor;
        logic [31:0] res;
        logic        rbor;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  a8, b8, diff8;
    logic [15:0] a16, b16, diff16;
    logic        busy8, done8, borrow8;
    logic        busy16, done16, borrow16;

    int checks = 0;
    int errors = 0;

    mdl_t m8  = '{0, 32'd0, 1'b0, 32'd0, 1'b0};
    mdl_t m16 = '{0, 32'd0, 1'b0, 32'd0, 1'b0};

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow_out(borrow16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t r;
        r.phase = 0;
        r.pend  = 32'd0;
        r.pbor  = 1'b0;
        r.res   = 32'd0;
        r.rbor  = 1'b0;
        return r;
    endfunction

    // phase 0: idle; 1..w: busy; w+1: done cycle with the result published
    function automatic mdl_t mstep(input mdl_t m, input int w, input logic st,
                                   input logic [31:0] aa, input logic [31:0] bb);
        mdl_t        r;
        logic [31:0] mask;
        r    = m;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (r.phase == 0) begin
            if (st) begin
                r.phase = 1;
                r.pend  = (aa - bb) & mask;
                r.pbor  = ((aa & mask) < (bb & mask));
            end
        end else if (r.phase <= w) begin
            r.phase = r.phase + 1;
            if (r.phase == w + 1) begin
                r.res  = r.pend;
                r.rbor = r.pbor;
            end
        end else begin
            r.phase = 0;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8  <= mreset();
            m16 <= mreset();
        end else begin
            m8  <= mstep(m8, 8, start8, 32'(a8), 32'(b8));
            m16 <= mstep(m16, 16, start16, 32'(a16), 32'(b16));
        end
    end

    task automatic check_dut(input string tag, input int w, input mdl_t m,
                             input logic bsy, input logic dn,
                             input logic [31:0] d, input logic bo);
        logic exp_busy;
        exp_busy = (m.phase >= 1) && (m.phase <= w);
        chk({tag, " busy"}, 32'(bsy), 32'(exp_busy));
        chk({tag, " done"}, 32'(dn), 32'(m.phase == w + 1));
        if (!exp_busy) begin
            chk({tag, " diff"}, d, m.res);
            chk({tag, " borrow_out"}, 32'(bo), 32'(m.rbor));
        end
    endtask

    // per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        check_dut("w8", 8, m8, busy8, done8, 32'(diff8), borrow8);
        check_dut("w16", 16, m16, busy16, done16, 32'(diff16), borrow16);
    end

    task automatic kick8(input logic [7:0] aa, input logic [7:0] bb);
        @(negedge clk);
        start8 = 1'b1;
        a8     = aa;
        b8     = bb;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int nbusy);
        int n;
        n     = 0;
        nbusy = 0;
        while (!done8 && n < 40) begin
            if (busy8) nbusy++;
            @(negedge clk);
            n++;
        end
        chk("w8 done seen", 32'(done8), 32'd1);
    endtask

    task automatic run8(input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] ed, input logic eb, input string name);
        int nb;
        kick8(aa, bb);
        wait_done8(nb);
        chk({name, " diff"}, 32'(diff8), 32'(ed));
        chk({name, " borrow_out"}, 32'(borrow8), 32'(eb));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int ndone;
        int last;
        int n;
        rst_n   = 1'b1;
        start8  = 1'b0;
        start16 = 1'b0;
        a8 = 8'd0;  b8 = 8'd0;
        a16 = 16'd0; b16 = 16'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy8), 32'd0);
        chk("reset diff", 32'(diff8), 32'd0);
        rst_n = 1'b1;

        // basic operation and latency
        kick8(8'd100, 8'd37);
        wait_done8(nb);
        chk("t1 busy cycles", 32'(nb), 32'd8);
        chk("t1 diff", 32'(diff8), 32'h3F);
        chk("t1 borrow_out", 32'(borrow8), 32'd0);

        run8(8'd5, 8'd10, 8'hFB, 1'b1, "t2a");
        run8(8'h00, 8'hFF, 8'h01, 1'b1, "t2b");
        run8(8'hA5, 8'hA5, 8'h00, 1'b0, "t2c");

        // start during RUN must be ignored
        kick8(8'd77, 8'd12);
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(nb);
        chk("t3 diff", 32'(diff8), 32'h41);
        chk("t3 borrow_out", 32'(borrow8), 32'd0);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("t3 extra done", 32'(ndone), 32'd0);

        // asynchronous reset in the middle of RUN
        kick8(8'd50, 8'd20);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t4 busy", 32'(busy8), 32'd0);
        chk("t4 done", 32'(done8), 32'd0);
        chk("t4 diff", 32'(diff8), 32'd0);
        chk("t4 borrow_out", 32'(borrow8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("t4 no done", 32'(ndone), 32'd0);
        run8(8'd50, 8'd20, 8'h1E, 1'b0, "t4 after");

        // start held high: back-to-back every WIDTH+2 cycles
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd1;
        ndone = 0;
        last  = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done8) begin
                chk("t5 diff", 32'(diff8), 32'd199);
                chk("t5 borrow_out", 32'(borrow8), 32'd0);
                if (last >= 0) chk("t5 spacing", 32'(cyc - last), 32'd10);
                last = cyc;
                ndone++;
            end
        end
        chk("t5 done count", 32'(ndone), 32'd6);
        start8 = 1'b0;
        repeat (3) @(negedge clk);

        // random operands on both widths, checked by the per-cycle model
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            start8  = 1'b1;
            start16 = 1'b1;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            @(negedge clk);
            start8  = 1'b0;
            start16 = 1'b0;
            n = 0;
            while (!done16 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("w16 done seen", 32'(done16), 32'd1);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
